// File: rtl/fetch_unit_pkg.sv
// Shared core constants: widths, NOP encoding, opcodes and a word-align helper.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;

   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: imem request/response, decode hand-off and redirect.
interface fetch_unit_if
   import fetch_unit_pkg::*;
   ();

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            resp_valid;
   logic [XLEN-1:0] resp_data;
   logic            ins_valid;
   logic            ins_ready;
   logic [XLEN-1:0] ins;
   logic [XLEN-1:0] ins_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   // fetch unit side
   modport master (
      output req_valid, req_addr, ins_valid, ins, ins_pc,
      input  req_ready, resp_valid, resp_data, ins_ready, redirect_valid, redirect_pc
   );

   // imem / decode / branch-unit side
   modport slave (
      input  req_valid, req_addr, ins_valid, ins, ins_pc,
      output req_ready, resp_valid, resp_data, ins_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, flush beats push/pop.
module fetch_unit_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // pointer and occupancy update; flush and reset empty the buffer
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // storage write; no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests,
// in-order response capture into a prefetch FIFO, redirect flush.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4,
   parameter int              MAX_OUTST  = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int OW = $clog2(MAX_OUTST+1);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [OW-1:0]   outst;
   logic [OW-1:0]   outst_next;
   logic [OW-1:0]   outst_after_resp;
   logic [OW-1:0]   drop;
   logic            rst_q;
   logic            accept;
   logic            push;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full;
   logic            fifo_empty;
   logic [SW-1:0]   credit_sum;
   logic [XLEN-1:0] redirect_target;

   // outstanding reads hold a FIFO slot each, so a returning word always fits
   assign credit_sum    = SW'(outst) + SW'(fifo_count);
   assign bus.req_valid = !rst_q && !bus.redirect_valid
                          && (outst < OW'(MAX_OUTST))
                          && (credit_sum < SW'(FIFO_DEPTH));
   assign bus.req_addr  = fetch_pc;
   assign accept        = bus.req_valid && bus.req_ready;

   assign outst_after_resp = bus.resp_valid ? outst - 1'b1 : outst;
   assign push             = bus.resp_valid && (drop == '0) && !bus.redirect_valid;
   assign redirect_target  = word_align(bus.redirect_pc);

   assign bus.ins_valid = !fifo_empty;

   // outstanding count after this cycle's accept and response
   always_comb begin
      outst_next = outst;
      unique case ({accept, bus.resp_valid})
         2'b10:   outst_next = outst + 1'b1;
         2'b01:   outst_next = outst - 1'b1;
         default: outst_next = outst;
      endcase
   end

   // one-cycle request blackout after reset
   always_ff @(posedge clk) begin
      rst_q <= rst;
   end

   // PCs and in-flight bookkeeping; redirect outranks normal flow
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         outst    <= '0;
         drop     <= '0;
      end else if (bus.redirect_valid) begin
         fetch_pc <= redirect_target;
         resp_pc  <= redirect_target;
         outst    <= outst_after_resp;
         // every read still in flight is stale; outst already counts earlier
         // pending drops, so this carries them forward without double counting
         drop     <= outst_after_resp;
      end else begin
         if (accept) fetch_pc <= fetch_pc + XLEN'(4);
         outst <= outst_next;
         if (bus.resp_valid) begin
            if (drop != '0) drop    <= drop - 1'b1;
            else            resp_pc <= resp_pc + XLEN'(4);
         end
      end
   end

   fetch_unit_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (bus.ins_ready),
      .flush (bus.redirect_valid),
      .wdata ({resp_pc, bus.resp_data}),
      .rdata ({bus.ins_pc, bus.ins}),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_resp_without_req: assert property (@(posedge clk) disable iff (rst)
      !(bus.resp_valid && (outst == '0)));

   a_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(push && fifo_full));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } obs_t;

   typedef struct {
      logic [31:0] pc_a;
      logic        two;
      logic [31:0] pc_b;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] e2;
   } redir_vec_t;

   logic clk;
   logic rst;
   logic hold;
   int   checks;
   int   failures;
   int   gaps;

   obs_t        obs [$];
   logic [31:0] iss [$];
   logic [31:0] imq [$];
   redir_vec_t  vecs [6];

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC   (32'h0),
      .FIFO_DEPTH (4),
      .MAX_OUTST  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic chk_obs(input string name, input int i, input logic [31:0] exp_pc);
      if (obs.size() <= i) begin
         checks++;
         failures++;
         $display("FAIL %s[%0d] actual=missing required=%h", name, i, exp_pc);
      end else begin
         chk({name, "_pc"}, obs[i].pc, exp_pc);
         chk({name, "_ins"}, obs[i].ins, exp_pc ^ KEY);
      end
   endtask

   task automatic chk_iss(input string name, input int i, input logic [31:0] exp_addr);
      if (iss.size() <= i) begin
         checks++;
         failures++;
         $display("FAIL %s[%0d] actual=missing required=%h", name, i, exp_addr);
      end else begin
         chk(name, iss[i], exp_addr);
      end
   endtask

   // one clock: sample handshakes, advance, then update the 1-cycle imem model
   task automatic tick();
      logic        acc;
      logic        pop;
      logic [31:0] a;
      logic [31:0] p;
      logic [31:0] d;
      #1;
      acc = bus.req_valid && bus.req_ready && !rst;
      a   = bus.req_addr;
      pop = bus.ins_valid && bus.ins_ready && !bus.redirect_valid && !rst;
      p   = bus.ins_pc;
      d   = bus.ins;
      @(posedge clk);
      #1;
      if (rst) begin
         imq.delete();
         bus.resp_valid = 1'b0;
      end else begin
         if (acc) begin
            imq.push_back(a);
            iss.push_back(a);
         end
         if (pop) obs.push_back('{pc: p, ins: d});
         if (!hold && imq.size() > 0) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = imq.pop_front() ^ KEY;
         end else begin
            bus.resp_valid = 1'b0;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic reset_assert();
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      hold = 1'b0;
      ticks(2);
      obs.delete();
      iss.delete();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      hold = 1'b0;
      bus.req_ready = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_data = '0;
      bus.ins_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = '0;

      vecs[0] = '{pc_a: 32'h0000_0100, two: 1'b0, pc_b: 32'h0, e0: 32'h0000_0100, e1: 32'h0000_0104, e2: 32'h0000_0108};
      vecs[1] = '{pc_a: 32'h0000_0103, two: 1'b0, pc_b: 32'h0, e0: 32'h0000_0100, e1: 32'h0000_0104, e2: 32'h0000_0108};
      vecs[2] = '{pc_a: 32'h0000_0206, two: 1'b0, pc_b: 32'h0, e0: 32'h0000_0204, e1: 32'h0000_0208, e2: 32'h0000_020C};
      vecs[3] = '{pc_a: 32'h0000_0103, two: 1'b1, pc_b: 32'hFFFF_FFF8, e0: 32'hFFFF_FFF8, e1: 32'hFFFF_FFFC, e2: 32'h0000_0000};
      vecs[4] = '{pc_a: 32'h0000_0040, two: 1'b1, pc_b: 32'hFFFF_FFFF, e0: 32'hFFFF_FFFC, e1: 32'h0000_0000, e2: 32'h0000_0004};
      vecs[5] = '{pc_a: 32'h8000_0001, two: 1'b0, pc_b: 32'h0, e0: 32'h8000_0000, e1: 32'h8000_0004, e2: 32'h8000_0008};

      // reset values, then continuous streaming
      reset_assert();
      chk("rst_req_valid", {31'b0, bus.req_valid}, 32'h0);
      chk("rst_ins_valid", {31'b0, bus.ins_valid}, 32'h0);
      chk("rst_req_addr", bus.req_addr, 32'h0);
      chk("rst_outst", 32'(dut.outst), 32'h0);
      rst = 1'b0;
      bus.req_ready = 1'b1;
      bus.ins_ready = 1'b1;
      gaps = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i >= 10 && !bus.ins_valid) gaps++;
      end
      chk("stream_gaps", 32'(gaps), 32'h0);
      for (int i = 0; i < 6; i++) begin
         chk_iss("stream_addr", i, 32'(i * 4));
         chk_obs("stream", i, 32'(i * 4));
      end

      // decode stalled: FIFO fills to depth, requests stop, then drain
      reset_assert();
      rst = 1'b0;
      bus.req_ready = 1'b1;
      bus.ins_ready = 1'b0;
      ticks(20);
      chk("bp_req_valid", {31'b0, bus.req_valid}, 32'h0);
      chk("bp_ins_valid", {31'b0, bus.ins_valid}, 32'h1);
      chk("bp_count", 32'(dut.u_fifo.count), 32'h4);
      chk("bp_outst", 32'(dut.outst), 32'h0);
      chk("bp_issued", 32'(iss.size()), 32'h4);
      chk("bp_req_addr", bus.req_addr, 32'h10);
      obs.delete();
      iss.delete();
      bus.ins_ready = 1'b1;
      ticks(12);
      for (int i = 0; i < 5; i++) chk_obs("bp_drain", i, 32'(i * 4));
      chk_iss("bp_resume", 0, 32'h10);

      // two reads in flight at 0x20/0x24, redirect drops both
      reset_assert();
      rst = 1'b0;
      bus.req_ready = 1'b1;
      bus.ins_ready = 1'b1;
      hold = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h20;
      tick();
      bus.redirect_valid = 1'b0;
      iss.delete();
      ticks(4);
      chk("fl_issued", 32'(iss.size()), 32'h2);
      chk_iss("fl_addr", 0, 32'h20);
      chk_iss("fl_addr", 1, 32'h24);
      chk("fl_outst", 32'(dut.outst), 32'h2);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      tick();
      chk("fl_drop", 32'(dut.drop), 32'h2);
      bus.redirect_valid = 1'b0;
      hold = 1'b0;
      obs.delete();
      ticks(12);
      chk_obs("fl_first", 0, 32'h100);
      chk_obs("fl_second", 1, 32'h104);

      // redirect coinciding with a response and a decode pop
      reset_assert();
      rst = 1'b0;
      bus.req_ready = 1'b0;
      bus.ins_ready = 1'b0;
      tick();
      bus.req_ready = 1'b1;
      tick();
      hold = 1'b1;
      ticks(2);
      chk("co_outst", 32'(dut.outst), 32'h2);
      chk("co_count", 32'(dut.u_fifo.count), 32'h1);
      chk("co_req_valid", {31'b0, bus.req_valid}, 32'h0);
      hold = 1'b0;
      tick();
      chk("co_resp_valid", {31'b0, bus.resp_valid}, 32'h1);
      bus.ins_ready = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h300;
      obs.delete();
      iss.delete();
      tick();
      chk("co_ins_valid", {31'b0, bus.ins_valid}, 32'h0);
      chk("co_count_after", 32'(dut.u_fifo.count), 32'h0);
      chk("co_outst_after", 32'(dut.outst), 32'h1);
      chk("co_drop_after", 32'(dut.drop), 32'h1);
      chk("co_no_issue", 32'(iss.size()), 32'h0);
      bus.redirect_valid = 1'b0;
      ticks(12);
      chk_obs("co_first", 0, 32'h300);
      chk_obs("co_second", 1, 32'h304);

      // table of redirect targets: alignment, back-to-back, address wrap
      reset_assert();
      rst = 1'b0;
      bus.req_ready = 1'b1;
      bus.ins_ready = 1'b1;
      ticks(6);
      for (int v = 0; v < 6; v++) begin
         obs.delete();
         iss.delete();
         bus.redirect_valid = 1'b1;
         bus.redirect_pc = vecs[v].pc_a;
         tick();
         if (vecs[v].two) begin
            bus.redirect_pc = vecs[v].pc_b;
            tick();
         end
         bus.redirect_valid = 1'b0;
         ticks(10);
         chk_iss("rd_addr", 0, vecs[v].e0);
         chk_obs("rd_e0", 0, vecs[v].e0);
         chk_obs("rd_e1", 1, vecs[v].e1);
         chk_obs("rd_e2", 2, vecs[v].e2);
      end

      // reset in the middle of traffic, then refetch from RESET_PC
      reset_assert();
      rst = 1'b0;
      bus.req_ready = 1'b1;
      bus.ins_ready = 1'b0;
      ticks(5);
      hold = 1'b1;
      ticks(3);
      rst = 1'b1;
      tick();
      chk("mr_req_valid", {31'b0, bus.req_valid}, 32'h0);
      chk("mr_ins_valid", {31'b0, bus.ins_valid}, 32'h0);
      chk("mr_req_addr", bus.req_addr, 32'h0);
      chk("mr_count", 32'(dut.u_fifo.count), 32'h0);
      chk("mr_outst", 32'(dut.outst), 32'h0);
      chk("mr_drop", 32'(dut.drop), 32'h0);
      rst = 1'b0;
      hold = 1'b0;
      bus.ins_ready = 1'b1;
      obs.delete();
      iss.delete();
      ticks(12);
      chk_iss("mr_refetch", 0, 32'h0);
      for (int i = 0; i < 4; i++) chk_obs("mr_stream", i, 32'(i * 4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
